// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the instruction
//   fetch requester (IF, read-only) and the data requester (MEM stage,
//   read/write). One access is in flight at a time; data requests have
//   priority, but IF is granted after at most MAX_DATA_STREAK consecutive
//   data grants during which it was waiting.
//
// Ports
//   clk_i, rst_i                  clock (rising edge), async active-low reset
//   if_req_i, if_addr_i           IF read request (level, held until ack)
//   if_ack_o, if_rdata_o          IF completion pulse and read data (held)
//   if_stall_o                    if_req_i & ~if_ack_o
//   d_req_i, d_we_i, d_addr_i,    data request (level, held until ack),
//   d_wdata_i                     write flag, address, write data
//   d_ack_o, d_rdata_o            data completion pulse and read data
//                                 (updated on reads only)
//   d_stall_o                     d_req_i & ~d_ack_o
//   mem_en_o, mem_we_o,           memory enable (high LAT cycles), write
//   mem_addr_o, mem_wdata_o       enable, address and write data
//   mem_rdata_i                   memory read data, valid in last enable cycle

module mem_port_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned LAT             = 2,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_stall_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_stall_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT   = 4'(LAT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] streak;
    logic       owner;      // 1: data requester, 0: IF
    logic       grant_d;
    logic       grant_if;

    assign if_stall_o = if_req_i & ~if_ack_o;
    assign d_stall_o  = d_req_i  & ~d_ack_o;

    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_if   = 1'b0;
        case (state)
            IDLE: begin
                // IF only wins against a pending data request once the
                // data side has used up its streak allowance.
                if (d_req_i && (!if_req_i || (streak < STREAK_MAX))) begin
                    grant_d = 1'b1;
                end else if (if_req_i) begin
                    grant_if = 1'b1;
                end
                if (grant_d || grant_if) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt         <= '0;
            streak      <= '0;
            owner       <= 1'b0;
            if_ack_o    <= 1'b0;
            if_rdata_o  <= '0;
            d_ack_o     <= 1'b0;
            d_rdata_o   <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                        owner       <= 1'b1;
                        cnt         <= CNT_INIT;
                        // Streak only counts data grants that made IF wait;
                        // bounded by STREAK_MAX so it cannot wrap.
                        streak      <= if_req_i ? streak + 4'd1 : '0;
                    end else if (grant_if) begin
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        owner       <= 1'b0;
                        cnt         <= CNT_INIT;
                        streak      <= '0;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        mem_en_o <= 1'b0;
                        mem_we_o <= 1'b0;
                        if (owner) begin
                            d_ack_o <= 1'b1;
                            if (!mem_we_o) begin
                                d_rdata_o <= mem_rdata_i;
                            end
                        end else begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= mem_rdata_i;
                        end
                    end
                end
                RESP: begin
                    if_ack_o <= 1'b0;
                    d_ack_o  <= 1'b0;
                end
                default: begin
                    if_ack_o <= 1'b0;
                    d_ack_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter: reset state, a table of
//   single/contended transactions, directed multi-cycle sequences (write
//   keeps read data, IF starvation bound, request drop, mid-access reset),
//   a LAT=1 instance, and randomized traffic against a transaction model.

module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int MAXS = 4;

    logic        clk;
    logic        rst_i;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // second instance: LAT=1, streak limit 1
    logic        if_req1;
    logic [31:0] if_addr1;
    logic        if_ack1;
    logic [31:0] if_rdata1;
    logic        if_stall1;
    logic        d_req1;
    logic        d_we1;
    logic [31:0] d_addr1;
    logic [31:0] d_wdata1;
    logic        d_ack1;
    logic [31:0] d_rdata1;
    logic        d_stall1;
    logic        mem_en1;
    logic        mem_we1;
    logic [31:0] mem_addr1;
    logic [31:0] mem_wdata1;
    logic [31:0] mem_rdata1;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    int          streak_m;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT), .MAX_DATA_STREAK(MAXS)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack),
        .if_rdata_o(if_rdata), .if_stall_o(if_stall),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ack_o(d_ack), .d_rdata_o(d_rdata), .d_stall_o(d_stall),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1), .MAX_DATA_STREAK(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req1), .if_addr_i(if_addr1), .if_ack_o(if_ack1),
        .if_rdata_o(if_rdata1), .if_stall_o(if_stall1),
        .d_req_i(d_req1), .d_we_i(d_we1), .d_addr_i(d_addr1), .d_wdata_i(d_wdata1),
        .d_ack_o(d_ack1), .d_rdata_o(d_rdata1), .d_stall_o(d_stall1),
        .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
        .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model content
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10) return 32'h8C0A0004;
        if (a == 32'h20) return 32'h00000055;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Memory only presents valid data in the last cycle of an enable burst.
    int en_run;
    int en_run1;
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            en_run  <= 0;
            en_run1 <= 0;
        end else begin
            en_run  <= mem_en  ? en_run + 1  : 0;
            en_run1 <= mem_en1 ? en_run1 + 1 : 0;
        end
    end
    assign mem_rdata  = (mem_en  && en_run  == LAT - 1) ? mem_val(mem_addr)  : 32'hBAD0BAD0;
    assign mem_rdata1 = (mem_en1 && en_run1 == 0)       ? mem_val(mem_addr1) : 32'hBAD1BAD1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i   = 1'b0;
        if_req  = 1'b0; if_addr = '0;
        d_req   = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        if_req1 = 1'b0; if_addr1 = '0;
        d_req1  = 1'b0; d_we1 = 1'b0; d_addr1 = '0; d_wdata1 = '0;
        @(negedge clk);
        rst_i        = 1'b1;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        streak_m     = 0;
    endtask

    // Inputs are already driven at this negedge and the DUT is idle; the
    // grant happens at the next rising edge. Ends at the negedge where the
    // next request may be presented. The winner drops its request at the end.
    task automatic run_txn(input string tag, input bit exp_d, input logic [31:0] addr,
                           input bit we, input logic [31:0] wdata, input bit drop);
        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            chk({tag, ".en"},    mem_en, 1'b1);
            chk({tag, ".we"},    mem_we, exp_d & we);
            chk({tag, ".addr"},  mem_addr, addr);
            if (exp_d && we) chk({tag, ".wdata"}, mem_wdata, wdata);
            chk({tag, ".ackif0"}, if_ack, 1'b0);
            chk({tag, ".ackd0"},  d_ack, 1'b0);
            chk({tag, ".stallif"}, if_stall, if_req);
            chk({tag, ".stalld"},  d_stall, d_req);
            if (drop && c == 0) begin
                if (exp_d) d_req = 1'b0; else if_req = 1'b0;
            end
        end
        @(negedge clk);
        if (exp_d && !we) exp_d_rdata = mem_val(addr);
        if (!exp_d) exp_if_rdata = mem_val(addr);
        chk({tag, ".en_off"},  mem_en, 1'b0);
        chk({tag, ".we_off"},  mem_we, 1'b0);
        chk({tag, ".ackif"},   if_ack, !exp_d);
        chk({tag, ".ackd"},    d_ack, exp_d);
        chk({tag, ".ifrdata"}, if_rdata, exp_if_rdata);
        chk({tag, ".drdata"},  d_rdata, exp_d_rdata);
        chk({tag, ".stallif_ack"}, if_stall, exp_d ? if_req : 1'b0);
        chk({tag, ".stalld_ack"},  d_stall, exp_d ? 1'b0 : d_req);
        @(negedge clk);
        chk({tag, ".resp_ackif"}, if_ack, 1'b0);
        chk({tag, ".resp_ackd"},  d_ack, 1'b0);
        chk({tag, ".resp_en"},    mem_en, 1'b0);
        chk({tag, ".hold_if"},    if_rdata, exp_if_rdata);
        chk({tag, ".hold_d"},     d_rdata, exp_d_rdata);
        if (exp_d) d_req = 1'b0; else if_req = 1'b0;
    endtask

    typedef struct {
        string       name;
        bit          ifr;
        logic [31:0] ifa;
        bit          dr;
        bit          dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        bit          exp_d;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"if_only",   1, 32'h10, 0, 0, 32'h0,   32'h0,        0};
        vecs[1] = '{"d_read",    0, 32'h0,  1, 0, 32'h20,  32'h0,        1};
        vecs[2] = '{"d_write",   0, 32'h0,  1, 1, 32'h24,  32'hDEADBEEF, 1};
        vecs[3] = '{"both_rd",   1, 32'h10, 1, 0, 32'h20,  32'h0,        1};
        vecs[4] = '{"both_wr",   1, 32'h30, 1, 1, 32'h34,  32'h12345678, 1};
        vecs[5] = '{"d_read100", 0, 32'h0,  1, 0, 32'h100, 32'h0,        1};

        rst_i = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        if_req1 = 0; if_addr1 = '0; d_req1 = 0; d_we1 = 0; d_addr1 = '0; d_wdata1 = '0;
        exp_if_rdata = '0; exp_d_rdata = '0; streak_m = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.if_ack", if_ack, 1'b0);
        chk("rst.d_ack", d_ack, 1'b0);
        chk("rst.if_rdata", if_rdata, 32'h0);
        chk("rst.d_rdata", d_rdata, 32'h0);
        chk("rst.mem_en", mem_en, 1'b0);
        chk("rst.mem_we", mem_we, 1'b0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        rst_i = 1'b1;

        // table-driven single / contended transactions
        for (int v = 0; v < 6; v++) begin
            do_reset();
            if_req = vecs[v].ifr; if_addr = vecs[v].ifa;
            d_req = vecs[v].dr; d_we = vecs[v].dwe; d_addr = vecs[v].da; d_wdata = vecs[v].dwd;
            if (vecs[v].exp_d)
                run_txn({vecs[v].name, ".1st"}, 1, vecs[v].da, vecs[v].dwe, vecs[v].dwd, 0);
            else
                run_txn({vecs[v].name, ".1st"}, 0, vecs[v].ifa, 0, 32'h0, 0);
            if (vecs[v].ifr && vecs[v].dr)
                run_txn({vecs[v].name, ".2nd"}, 0, vecs[v].ifa, 0, 32'h0, 0);
        end

        // write after read keeps d_rdata
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h20;
        run_txn("rw.read", 1, 32'h20, 0, 32'h0, 0);
        d_req = 1; d_we = 1; d_addr = 32'h24; d_wdata = 32'hDEADBEEF;
        run_txn("rw.write", 1, 32'h24, 1, 32'hDEADBEEF, 0);

        // starvation bound: 4 data grants, then IF, then data again
        do_reset();
        if_req = 1; if_addr = 32'h80;
        for (int k = 0; k < MAXS; k++) begin
            d_req = 1; d_we = 0; d_addr = 32'h200 + 32'(k * 4);
            run_txn("starve.d", 1, 32'h200 + 32'(k * 4), 0, 32'h0, 0);
        end
        d_req = 1; d_addr = 32'h300;
        run_txn("starve.if", 0, 32'h80, 0, 32'h0, 0);
        if_req = 1; if_addr = 32'h84;
        run_txn("starve.dagain", 1, 32'h300, 0, 32'h0, 0);
        if_req = 0;

        // requester drops mid-access, ack still pulses
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h48;
        run_txn("drop", 1, 32'h48, 0, 32'h0, 1);

        // reset mid-access
        do_reset();
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        chk("midrst.en_before", mem_en, 1'b1);
        #2 rst_i = 1'b0;
        #1;
        chk("midrst.en", mem_en, 1'b0);
        chk("midrst.ifack", if_ack, 1'b0);
        chk("midrst.dack", d_ack, 1'b0);
        chk("midrst.we", mem_we, 1'b0);
        @(negedge clk);
        chk("midrst.noack", if_ack, 1'b0);
        rst_i = 1'b1;
        exp_if_rdata = '0; exp_d_rdata = '0; streak_m = 0;
        run_txn("midrst.after", 0, 32'h10, 0, 32'h0, 0);

        // LAT=1 instance
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lat1.idle_en", mem_en1, 1'b0);
        end
        d_req1 = 1; d_addr1 = 32'h20;
        @(negedge clk);
        chk("lat1.en", mem_en1, 1'b1);
        chk("lat1.ack_early", d_ack1, 1'b0);
        @(negedge clk);
        chk("lat1.ack", d_ack1, 1'b1);
        chk("lat1.rdata", d_rdata1, 32'h55);
        chk("lat1.en_off", mem_en1, 1'b0);
        @(negedge clk);
        chk("lat1.ack_clr", d_ack1, 1'b0);
        // both pending, streak limit 1: data then IF although data stays
        d_addr1 = 32'h60; if_req1 = 1; if_addr1 = 32'h10;
        @(negedge clk);
        chk("lat1.both_en", mem_en1, 1'b1);
        chk("lat1.both_addr", mem_addr1, 32'h60);
        @(negedge clk);
        chk("lat1.both_dack", d_ack1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("lat1.if_addr", mem_addr1, 32'h10);
        @(negedge clk);
        chk("lat1.if_ack", if_ack1, 1'b1);
        chk("lat1.if_dack", d_ack1, 1'b0);
        chk("lat1.if_rdata", if_rdata1, 32'h8C0A0004);
        d_req1 = 0; if_req1 = 0;

        // randomized traffic against a transaction-level model
        do_reset();
        for (int t = 0; t < 300; t++) begin
            bit win_d;
            if (!if_req && $urandom_range(3, 0) != 0) begin
                if_req = 1; if_addr = $urandom & 32'hFFFC;
            end
            if (!d_req && $urandom_range(3, 0) != 0) begin
                d_req = 1; d_we = 1'($urandom_range(1, 0));
                d_addr = $urandom & 32'hFFFC; d_wdata = $urandom;
            end
            if (!if_req && !d_req) begin
                @(negedge clk);
                chk("rnd.idle_en", mem_en, 1'b0);
                chk("rnd.idle_ack", if_ack | d_ack, 1'b0);
                continue;
            end
            win_d = d_req && (!if_req || streak_m < MAXS);
            if (win_d) streak_m = if_req ? streak_m + 1 : 0;
            else streak_m = 0;
            if (win_d) run_txn("rnd.d", 1, d_addr, d_we, d_wdata, 0);
            else       run_txn("rnd.if", 0, if_addr, 0, 32'h0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
